// File: rtl/udc_bus_master.sv
// udc_bus_master: host sequencer for the UDC up/down counter-tester.
// Accepts one PLR/ULR/LLR/CCR configuration, writes it over the UDC chip bus,
// reads back and verifies all four registers, issues one start pulse, then
// waits for end-of-cycle (with watchdog) and reports done/fail/fail_code.
// Ports: clk, reset (async, active-high); cfg_* handshake and values;
//   bus_dout/bus_doe/bus_din, ncs/nwr/nrd, a1/a0, start_out toward the UDC;
//   ec_in/err_in from the UDC; done/fail/fail_code job result.
module udc_bus_master #(
  parameter int unsigned TIMEOUT_W = 16,
  parameter int unsigned TIMEOUT   = 60000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_plr,
  input  logic [7:0] cfg_ulr,
  input  logic [7:0] cfg_llr,
  input  logic [7:0] cfg_ccr,
  output logic [7:0] bus_dout,
  output logic       bus_doe,
  input  logic [7:0] bus_din,
  output logic       ncs,
  output logic       nwr,
  output logic       nrd,
  output logic       a1,
  output logic       a0,
  output logic       start_out,
  input  logic       ec_in,
  input  logic       err_in,
  output logic       done,
  output logic       fail,
  output logic [1:0] fail_code
);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_WRITE, S_RD_ADDR, S_RD_SAMPLE,
    S_ARM, S_START, S_WAIT_EC, S_DONE
  } state_t;

  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT - 1);

  state_t               r_state, w_state_nxt;
  logic [1:0]           r_idx, w_idx_nxt;
  logic [7:0]           r_cfg [4];     // 0 PLR, 1 ULR, 2 LLR, 3 CCR
  logic [1:0]           w_code_nxt;
  logic [TIMEOUT_W-1:0] r_wd, w_wd_nxt;

  logic       r_ec_tog, r_ec_s1, r_ec_s2, r_ec_ref;
  logic       w_ec_seen;

  logic       w_ncs, w_nwr, w_nrd, w_doe, w_start, w_done, w_fail, w_ready;
  logic [1:0] w_addr;
  logic [7:0] w_dout;

  // ec_in is shorter than a clock period: catch it as a toggle, then bring
  // the toggle into the clk domain and detect its change.
  always_ff @(posedge ec_in or posedge reset) begin
    if (reset) r_ec_tog <= 1'b0;
    else       r_ec_tog <= ~r_ec_tog;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ec_s1  <= 1'b0;
      r_ec_s2  <= 1'b0;
      r_ec_ref <= 1'b0;
    end else begin
      r_ec_s1  <= r_ec_tog;
      r_ec_s2  <= r_ec_s1;
      r_ec_ref <= r_ec_s2;
    end
  end

  assign w_ec_seen = r_ec_s2 ^ r_ec_ref;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) r_cfg[i] <= '0;
    end else if (r_state == S_IDLE && cfg_valid) begin
      r_cfg[0] <= cfg_plr;
      r_cfg[1] <= cfg_ulr;
      r_cfg[2] <= cfg_llr;
      r_cfg[3] <= cfg_ccr;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_code_nxt  = fail_code;
    w_wd_nxt    = '0;
    case (r_state)
      S_IDLE: begin
        if (cfg_valid) begin
          w_state_nxt = S_CHECK;
          w_idx_nxt   = '0;
          w_code_nxt  = 2'd0;
        end
      end
      S_CHECK: begin
        if (r_cfg[2] > r_cfg[0] || r_cfg[0] > r_cfg[1]) begin
          w_state_nxt = S_DONE;
          w_code_nxt  = 2'd1;
        end else begin
          w_state_nxt = S_WRITE;
          w_idx_nxt   = '0;
        end
      end
      S_WRITE: begin
        if (r_idx == 2'd3) begin
          w_state_nxt = S_RD_ADDR;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt   = r_idx + 2'd1;
        end
      end
      S_RD_ADDR: w_state_nxt = S_RD_SAMPLE;
      S_RD_SAMPLE: begin
        if (bus_din != r_cfg[r_idx]) begin
          w_state_nxt = S_DONE;
          w_code_nxt  = 2'd2;
        end else if (r_idx == 2'd3) begin
          w_state_nxt = S_ARM;
        end else begin
          w_state_nxt = S_RD_ADDR;
          w_idx_nxt   = r_idx + 2'd1;
        end
      end
      S_ARM: begin
        if (err_in) begin
          w_state_nxt = S_DONE;
          w_code_nxt  = 2'd1;
        end else begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_state_nxt = S_WAIT_EC;
        w_wd_nxt    = TIMEOUT_W'(1);
      end
      S_WAIT_EC: begin
        w_wd_nxt = r_wd + TIMEOUT_W'(1);
        // ec has priority over a coincident watchdog expiry
        if (w_ec_seen) begin
          w_state_nxt = S_DONE;
          w_code_nxt  = 2'd0;
        end else if (r_wd == WD_LAST) begin
          w_state_nxt = S_DONE;
          w_code_nxt  = 2'd3;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered with it, so each
  // output register holds the value belonging to the current state.
  always_comb begin
    w_ncs   = 1'b1;
    w_nwr   = 1'b1;
    w_nrd   = 1'b1;
    w_doe   = 1'b0;
    w_dout  = '0;
    w_addr  = '0;
    w_start = 1'b0;
    w_done  = 1'b0;
    w_ready = 1'b0;
    case (w_state_nxt)
      S_IDLE: w_ready = 1'b1;
      S_WRITE: begin
        w_ncs  = 1'b0;
        w_nwr  = 1'b0;
        w_doe  = 1'b1;
        w_addr = w_idx_nxt;
        w_dout = r_cfg[w_idx_nxt];
      end
      S_RD_ADDR, S_RD_SAMPLE: begin
        w_ncs  = 1'b0;
        w_nrd  = 1'b0;
        w_addr = w_idx_nxt;
      end
      S_ARM, S_WAIT_EC: w_ncs = 1'b0;
      S_START: begin
        w_ncs   = 1'b0;
        w_start = 1'b1;
      end
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
    w_fail = w_done && (w_code_nxt != 2'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_wd      <= '0;
      fail_code <= '0;
      ncs       <= 1'b1;
      nwr       <= 1'b1;
      nrd       <= 1'b1;
      a1        <= 1'b0;
      a0        <= 1'b0;
      bus_doe   <= 1'b0;
      bus_dout  <= '0;
      start_out <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_wd      <= w_wd_nxt;
      fail_code <= w_code_nxt;
      ncs       <= w_ncs;
      nwr       <= w_nwr;
      nrd       <= w_nrd;
      a1        <= w_addr[1];
      a0        <= w_addr[0];
      bus_doe   <= w_doe;
      bus_dout  <= w_dout;
      start_out <= w_start;
      done      <= w_done;
      fail      <= w_fail;
      cfg_ready <= w_ready;
    end
  end

endmodule

// File: tb/tb_udc_bus_master.sv
// Bench for udc_bus_master with a behavioural UDC model (write-once registers
// cleared by ec, readback mux, CCR-driven ec pulse) and a done scoreboard.
module tb_udc_bus_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid, cfg_ready;
  logic [7:0] cfg_plr, cfg_ulr, cfg_llr, cfg_ccr;
  logic [7:0] bus_dout, bus_din;
  logic       bus_doe, ncs, nwr, nrd, a1, a0, start_out;
  logic       ec_in, err_in, done, fail;
  logic [1:0] fail_code;

  always #5 clk = ~clk;

  udc_bus_master #(.TIMEOUT_W(16), .TIMEOUT(100)) dut (
    .clk(clk), .reset(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_plr(cfg_plr), .cfg_ulr(cfg_ulr), .cfg_llr(cfg_llr), .cfg_ccr(cfg_ccr),
    .bus_dout(bus_dout), .bus_doe(bus_doe), .bus_din(bus_din),
    .ncs(ncs), .nwr(nwr), .nrd(nrd), .a1(a1), .a0(a0),
    .start_out(start_out), .ec_in(ec_in), .err_in(err_in),
    .done(done), .fail(fail), .fail_code(fail_code)
  );

  typedef struct {
    logic       fail;
    logic [1:0] code;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- UDC model ----------------
  logic [7:0] m_reg [4];
  logic       m_lock [4];
  logic       m_ec_en;
  logic       m_run;
  logic       fire;
  int         m_cnt;
  int         cyc = 0;
  int         ec_cyc;

  assign bus_din = !nrd ? m_reg[{a1, a0}] : 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_reg[i]  <= 8'h00;
        m_lock[i] = 1'b0;
      end
      m_run = 1'b0;
    end else begin
      if (!ncs && !nwr) begin
        if (!m_lock[{a1, a0}]) m_reg[{a1, a0}] <= bus_dout;
        m_lock[{a1, a0}] = 1'b1;
      end
      fire = 1'b0;
      if (start_out && !m_run) begin
        m_cnt = int'(m_reg[3]);
        m_run = 1'b1;
        if (m_cnt == 0) fire = 1'b1;
      end else if (m_run) begin
        m_cnt--;
        if (m_cnt <= 0) fire = 1'b1;
      end
      if (fire) begin
        m_run = 1'b0;
        if (m_ec_en) begin
          ec_cyc = cyc;
          for (int i = 0; i < 4; i++) m_lock[i] = 1'b0;
          #1 ec_in = 1'b1;
          #2 ec_in = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int n_wr, n_rd, n_start, n_ncs, bad_start, done_cnt;
  int cyc_start, cyc_done;

  initial begin
    n_wr = 0; n_rd = 0; n_start = 0; n_ncs = 0; bad_start = 0; done_cnt = 0;
    cyc_start = 0; cyc_done = 0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (!ncs) n_ncs++;
      if (!ncs && !nwr) n_wr++;
      if (!ncs && !nrd) n_rd++;
      if (start_out) begin
        n_start++;
        cyc_start = cyc;
        if (!nwr || !nrd) bad_start++;
      end
      if (done) begin
        done_cnt++;
        cyc_done = cyc;
        if (sb_q.size() == 0) chk("unexpected_done", sb_q.size(), 1);
        else begin
          e = sb_q.pop_front();
          chk({e.name, "_fail"}, fail, e.fail);
          chk({e.name, "_code"}, fail_code, e.code);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [7:0] plr, ulr, llr, ccr,
                       input logic ef, input logic [1:0] ec, input string name, input bit push);
    for (int i = 0; i < 50 && !cfg_ready; i++) @(negedge clk);
    chk({name, "_ready"}, cfg_ready, 1);
    if (push) sb_q.push_back('{fail: ef, code: ec, name: name});
    n_wr = 0; n_rd = 0; n_start = 0; n_ncs = 0;
    cfg_plr = plr; cfg_ulr = ulr; cfg_llr = llr; cfg_ccr = ccr;
    cfg_valid = 1'b1;
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    chk({name, "_ready_drop"}, cfg_ready, 0);
  endtask

  task automatic wait_done(input string name, input int limit);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < limit && done_cnt == d0; i++) @(posedge clk);
    chk({name, "_done_seen"}, done_cnt - d0, 1);
  endtask

  task automatic reset_pulse();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int d0;
    rst = 1'b1; cfg_valid = 1'b0; err_in = 1'b0; ec_in = 1'b0; m_ec_en = 1'b1;
    cfg_plr = '0; cfg_ulr = '0; cfg_llr = '0; cfg_ccr = '0; ec_cyc = -1;
    repeat (2) @(negedge clk);
    chk("rst_ncs", ncs, 1);
    chk("rst_nwr", nwr, 1);
    chk("rst_nrd", nrd, 1);
    chk("rst_addr", {a1, a0}, 0);
    chk("rst_doe", bus_doe, 0);
    chk("rst_dout", bus_dout, 0);
    chk("rst_start", start_out, 0);
    chk("rst_done", {done, fail}, 0);
    chk("rst_code", fail_code, 0);
    chk("rst_ready", cfg_ready, 1);
    @(negedge clk) rst = 1'b0;

    // T1: normal job
    issue(8'd5, 8'd9, 8'd2, 8'd2, 1'b0, 2'd0, "t1", 1);
    wait_done("t1", 300);
    chk("t1_writes", n_wr, 4);
    chk("t1_read_cycles", n_rd, 8);
    chk("t1_starts", n_start, 1);
    chk("t1_udc_regs", {m_reg[0], m_reg[1], m_reg[2], m_reg[3]}, 32'h05090202);

    // T2: plr above ulr, rejected before any bus activity
    issue(8'd10, 8'd9, 8'd2, 8'd2, 1'b1, 2'd1, "t2", 1);
    wait_done("t2", 50);
    chk("t2_ncs_cycles", n_ncs, 0);
    repeat (3) @(negedge clk);
    chk("t2_code_hold", fail_code, 1);

    // T4: ccr=0, ec right after start
    ec_cyc = -1;
    issue(8'd3, 8'd7, 8'd1, 8'd0, 1'b0, 2'd0, "t4", 1);
    wait_done("t4", 300);
    chk("t4_ec_latency_le2", (ec_cyc >= cyc_start) && (ec_cyc - cyc_start <= 2), 1);
    chk("t4_starts", n_start, 1);

    // T5: no ec, watchdog expiry
    m_ec_en = 1'b0;
    issue(8'd4, 8'd8, 8'd2, 8'd5, 1'b1, 2'd3, "t5", 1);
    wait_done("t5", 400);
    chk("t5_start_to_done", cyc_done - cyc_start, 100);

    // T3: UDC still write-locked from T5, plr differs -> readback mismatch
    m_ec_en = 1'b1;
    issue(8'd6, 8'd8, 8'd2, 8'd5, 1'b1, 2'd2, "t3", 1);
    wait_done("t3", 300);
    chk("t3_starts", n_start, 0);
    chk("t3_writes", n_wr, 4);

    // err_in sampled at ARM
    reset_pulse();
    err_in = 1'b1;
    issue(8'd5, 8'd9, 8'd2, 8'd2, 1'b1, 2'd1, "t7", 1);
    wait_done("t7", 300);
    chk("t7_starts", n_start, 0);
    err_in = 1'b0;

    // T6: reset during WAIT_EC
    reset_pulse();
    m_ec_en = 1'b0;
    issue(8'd5, 8'd9, 8'd2, 8'd2, 1'b0, 2'd0, "t6", 0);
    for (int i = 0; i < 200 && n_start == 0; i++) @(posedge clk);
    chk("t6_started", n_start, 1);
    repeat (5) @(posedge clk);
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    chk("t6_ncs_async", ncs, 1);
    chk("t6_start_async", start_out, 0);
    chk("t6_ready_async", cfg_ready, 1);
    chk("t6_done_async", done, 0);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6_no_done", done_cnt - d0, 0);

    chk("start_while_strobe", bad_start, 0);
    chk("sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
